bypass_ctrl_n: RTL and testbench
================================

BYPASS_CTRL_N -- requirements
Module: bypass_ctrl_n

Parameters
REQ-001 SHALL have parameter NUM_RD, default 2, number of decode read ports.
REQ-002 SHALL have parameter NUM_SRC, default 8, number of forwarding sources; index 0 = youngest stage.
REQ-003 SHALL have parameter XLEN, default 32, data width.
REQ-004 SHALL have parameter REG_AW, default 5, register address width; NUM_REGS = 2**REG_AW.
REQ-005 SHALL have parameter LAT_W, default 3, width of the result-latency field.
REQ-006 SHALL have parameter TAG_W, default 4, width of the producer tag.

Interface
REQ-007 SHALL provide ports as follows; one clock, reset synchronous and active-low:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- rd_addr_i  in  NUM_RD*REG_AW  decode source register addresses
- rd_en_i  in  NUM_RD  port p reads a register
- iss_valid_i  in  1  decode issues an instruction this cycle
- iss_wr_en_i  in  1  issued instruction writes a register
- iss_rd_i  in  REG_AW  issued destination register
- iss_lat_i  in  LAT_W  cycles until the result is forwardable
- iss_tag_o  out  TAG_W  tag given to the issued instruction; travels down the pipeline
- src_wr_en_i  in  NUM_SRC  source stage holds a register write
- src_addr_i  in  NUM_SRC*REG_AW  source destination addresses
- src_data_i  in  NUM_SRC*XLEN  source result data
- src_rdy_i  in  NUM_SRC  source data is final (ALU done, mult last stage, cache hit)
- ret_en_i  in  1  writeback commits
- ret_addr_i  in  REG_AW  writeback address
- ret_tag_i  in  TAG_W  writeback tag
- flush_i  in  1  pipeline flush
- bypass_en_o  out  NUM_RD  forward data valid on port p
- bypass_data_o  out  NUM_RD*XLEN  forwarded data
- stall_core_o  out  1  hold decode
- stall_cnt_o  out  32  saturating count of stall cycles

Function
REQ-008 Scoreboard: SHALL hold per register a busy bit, an LAT_W countdown and a TAG_W owner tag.
REQ-009 Issue: iss_valid_i & iss_wr_en_i & !stall_core_o & iss_rd_i!=0 SHALL set entry busy=1, cnt=iss_lat_i, tag=iss_tag_o on the next edge.
REQ-010 Tag counter SHALL increment, wrapping modulo 2**TAG_W, on every accepted issue; iss_tag_o SHALL equal its current value.
REQ-011 Every busy entry with cnt>0 SHALL decrement by 1 each cycle and SHALL saturate at 0.
REQ-012 Retire: ret_en_i SHALL clear busy for ret_addr_i only when ret_tag_i equals the stored tag; a mismatch (WAW, older writer) SHALL leave the entry unchanged.
REQ-013 Issue and retire on the same register in one cycle: issue SHALL win.
REQ-014 flush_i SHALL clear all busy bits on the next edge and SHALL take priority over issue and retire; the tag counter SHALL NOT reset on flush.
REQ-015 Per port p: address 0, or rd_en_i[p]=0, SHALL give bypass_en_o[p]=0 and no stall contribution.
REQ-016 Per port p: SHALL select the lowest-index source i with src_wr_en_i[i]=1 and an address match; if src_rdy_i[i]=1 then bypass_en_o[p]=1 and data=src_data_i[i].
REQ-017 Per port p, stall contribution = (matched source with src_rdy_i=0) OR (scoreboard busy with cnt!=0).
REQ-018 With no match, SHALL drive bypass_en_o[p]=0 and bypass data all zeros.
REQ-019 stall_core_o SHALL be the OR of the contributions over all ports; bypass and stall outputs are combinational (0-cycle latency).
REQ-020 stall_cnt_o SHALL increment on each cycle with stall_core_o=1 and SHALL saturate at 2**32-1.

Reset
REQ-021 While rsn_i=0: all busy bits, counts and tags SHALL be 0, the tag counter 0, stall_cnt_o 0.
REQ-022 While rsn_i=0: bypass_en_o=0, bypass_data_o=0, stall_core_o=0, regardless of inputs.
REQ-023 Reset asserted mid-countdown SHALL discard every pending entry.

Structure
REQ-024 Package bypass_pkg SHALL hold XLEN, REG_AW, LAT_W, TAG_W defaults and the scoreboard-entry struct type.
REQ-025 SHALL provide sub-module bypass_port_sel (priority match plus scoreboard check for one port), instantiated NUM_RD times.

Verification
REQ-026 Source 0 (x5, 0xDEADBEEF, rdy=1) and source 6 (x5, 0x1, rdy=1); port 0 reads x5 -> bypass_en_o[0]=1, data 0xDEADBEEF, no stall.
REQ-027 Issue x7 with lat=4 -> stall on x7 reads for exactly 4 cycles, then a ready source match forwards; stall_cnt_o=4.
REQ-028 Source 2 matches x3 with rdy=0 (cache miss) -> stall_core_o=1; setting rdy=1 -> stall=0 and forward in the same cycle.
REQ-029 Issue x9 tag 1, then x9 tag 2, retire x9 tag 1 -> x9 stays busy; retire tag 2 -> busy clears.
REQ-030 Issue x4 lat=6, flush_i asserted after 2 cycles -> next cycle, x4 reads do not stall; port reads of x0 never stall or forward.
REQ-031 rsn_i=0 during pending lat=5 -> all outputs 0; after release, reading that register gives no stall.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared widths and scoreboard entry type for the
// decode-stage bypass / interlock controller.
package bypass_pkg;

  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_NUM_SRC = 8;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_LAT_W   = 3;
  localparam int DEF_TAG_W   = 4;

  typedef struct packed {
    logic                 busy;
    logic [DEF_LAT_W-1:0] cnt;
    logic [DEF_TAG_W-1:0] tag;
  } sb_entry_t;

endpackage

// File: rtl/bypass_port_sel.sv
// One decode read port: youngest-first source match
// plus in-flight scoreboard interlock.
module bypass_port_sel
  import bypass_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int LAT_W   = DEF_LAT_W
) (
  input  logic                      rd_en_i,
  input  logic [REG_AW-1:0]         rd_addr_i,
  input  logic [NUM_SRC-1:0]        src_wr_en_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]        src_rdy_i,
  input  logic                      sb_busy_i,
  input  logic [LAT_W-1:0]          sb_cnt_i,
  output logic                      byp_en_o,
  output logic [XLEN-1:0]           byp_data_o,
  output logic                      stall_o
);

  logic            act;
  logic            hit;
  logic            rdy;
  logic [XLEN-1:0] data;

  assign act = rd_en_i && (rd_addr_i != '0);

  // Scan oldest to youngest so the youngest match is left last.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_wr_en_i[i] &&
          src_addr_i[i*REG_AW +: REG_AW] == rd_addr_i) begin
        hit  = 1'b1;
        rdy  = src_rdy_i[i];
        data = src_data_i[i*XLEN +: XLEN];
      end
    end
  end

  assign byp_en_o   = act && hit && rdy;
  assign byp_data_o = byp_en_o ? data : '0;
  assign stall_o    = act && ((hit && !rdy) ||
                              (sb_busy_i && sb_cnt_i != '0));

endmodule

// File: rtl/bypass_ctrl_n.sv
// N-port operand bypass selector with a latency-counting
// scoreboard, tag-checked retire and decode stall counter.
module bypass_ctrl_n
  import bypass_pkg::*;
#(
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                      clk_i,
  input  logic                      rsn_i,
  input  logic [NUM_RD*REG_AW-1:0]  rd_addr_i,
  input  logic [NUM_RD-1:0]         rd_en_i,
  input  logic                      iss_valid_i,
  input  logic                      iss_wr_en_i,
  input  logic [REG_AW-1:0]         iss_rd_i,
  input  logic [LAT_W-1:0]          iss_lat_i,
  output logic [TAG_W-1:0]          iss_tag_o,
  input  logic [NUM_SRC-1:0]        src_wr_en_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]        src_rdy_i,
  input  logic                      ret_en_i,
  input  logic [REG_AW-1:0]         ret_addr_i,
  input  logic [TAG_W-1:0]          ret_tag_i,
  input  logic                      flush_i,
  output logic [NUM_RD-1:0]         bypass_en_o,
  output logic [NUM_RD*XLEN-1:0]    bypass_data_o,
  output logic                      stall_core_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int NUM_REGS = 2**REG_AW;

  sb_entry_t [NUM_REGS-1:0] sb_q, sb_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [31:0]              scnt_q, scnt_d;
  logic [NUM_RD-1:0]        p_en, p_stall;
  logic [NUM_RD*XLEN-1:0]   p_data;
  logic                     iss_acc;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [REG_AW-1:0] a;
    assign a = rd_addr_i[p*REG_AW +: REG_AW];

    bypass_port_sel #(
      .NUM_SRC (NUM_SRC),
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .LAT_W   (LAT_W)
    ) u_sel (
      .rd_en_i     (rd_en_i[p]),
      .rd_addr_i   (a),
      .src_wr_en_i (src_wr_en_i),
      .src_addr_i  (src_addr_i),
      .src_data_i  (src_data_i),
      .src_rdy_i   (src_rdy_i),
      .sb_busy_i   (sb_q[a].busy),
      .sb_cnt_i    (sb_q[a].cnt),
      .byp_en_o    (p_en[p]),
      .byp_data_o  (p_data[p*XLEN +: XLEN]),
      .stall_o     (p_stall[p])
    );
  end

  // Reset masks the combinational outputs regardless of inputs.
  assign bypass_en_o   = rsn_i ? p_en   : '0;
  assign bypass_data_o = rsn_i ? p_data : '0;
  assign stall_core_o  = rsn_i && (|p_stall);
  assign iss_tag_o     = tag_q;
  assign stall_cnt_o   = scnt_q;

  assign iss_acc = iss_valid_i && iss_wr_en_i && !stall_core_o &&
                   (iss_rd_i != '0) && !flush_i;

  always_comb begin
    sb_d = sb_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush_i) begin
        sb_d[r].busy = 1'b0;
      end else if (iss_acc && iss_rd_i == REG_AW'(r)) begin
        sb_d[r] = '{busy: 1'b1, cnt: iss_lat_i, tag: tag_q};
      end else begin
        if (ret_en_i && ret_addr_i == REG_AW'(r) &&
            ret_tag_i == sb_q[r].tag)
          sb_d[r].busy = 1'b0;
        if (sb_q[r].busy && sb_q[r].cnt != '0)
          sb_d[r].cnt = sb_q[r].cnt - 1'b1;
      end
    end
  end

  assign tag_d  = tag_q + TAG_W'(iss_acc);
  assign scnt_d = (stall_core_o && scnt_q != '1) ?
                  scnt_q + 32'd1 : scnt_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      sb_q   <= '0;
      tag_q  <= '0;
      scnt_q <= '0;
    end else begin
      sb_q   <= sb_d;
      tag_q  <= tag_d;
      scnt_q <= scnt_d;
    end
  end

endmodule

// File: tb/tb_bypass_ctrl_n.sv
// Scoreboard bench for bypass_ctrl_n: a behavioural model
// queues expected outputs per cycle, checked at negedge.
module tb_bypass_ctrl_n;

  logic        clk = 1'b0;
  logic        rsn;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_en;
  logic        iss_valid, iss_wr_en;
  logic [4:0]  iss_rd;
  logic [2:0]  iss_lat;
  logic [3:0]  iss_tag;
  logic [7:0]  src_wr_en, src_rdy;
  logic [39:0] src_addr;
  logic [255:0] src_data;
  logic        ret_en;
  logic [4:0]  ret_addr;
  logic [3:0]  ret_tag;
  logic        flush;
  logic [1:0]  byp_en;
  logic [63:0] byp_data;
  logic        stall;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  bypass_ctrl_n dut (
    .clk_i         (clk),
    .rsn_i         (rsn),
    .rd_addr_i     (rd_addr),
    .rd_en_i       (rd_en),
    .iss_valid_i   (iss_valid),
    .iss_wr_en_i   (iss_wr_en),
    .iss_rd_i      (iss_rd),
    .iss_lat_i     (iss_lat),
    .iss_tag_o     (iss_tag),
    .src_wr_en_i   (src_wr_en),
    .src_addr_i    (src_addr),
    .src_data_i    (src_data),
    .src_rdy_i     (src_rdy),
    .ret_en_i      (ret_en),
    .ret_addr_i    (ret_addr),
    .ret_tag_i     (ret_tag),
    .flush_i       (flush),
    .bypass_en_o   (byp_en),
    .bypass_data_o (byp_data),
    .stall_core_o  (stall),
    .stall_cnt_o   (stall_cnt)
  );

  typedef struct {
    logic [1:0]  en;
    logic [63:0] data;
    logic        stall;
    logic [31:0] scnt;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bit         m_busy [32];
  int unsigned m_cnt [32];
  int unsigned m_tag [32];
  int unsigned m_tagc = 0;
  int unsigned m_scnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_addr = '0; rd_en = '0;
    iss_valid = 0; iss_wr_en = 0; iss_rd = '0; iss_lat = '0;
    src_wr_en = '0; src_rdy = '0; src_addr = '0; src_data = '0;
    ret_en = 0; ret_addr = '0; ret_tag = '0; flush = 0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a,
                         input logic [31:0] d, input logic r);
    src_wr_en[i] = 1'b1;
    src_addr[i*5 +: 5] = a;
    src_data[i*32 +: 32] = d;
    src_rdy[i] = r;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic issue(input logic [4:0] a, input logic [2:0] l);
    iss_valid = 1; iss_wr_en = 1; iss_rd = a; iss_lat = l;
  endtask

  task automatic cyc();
    exp_t e, g;
    logic [1:0] st;
    logic [4:0] a;
    bit found, acc, nb;
    e.en = '0; e.data = '0; st = '0;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      if (rd_en[p] && a != 0) begin
        found = 0;
        for (int i = 0; i < 8; i++)
          if (!found && src_wr_en[i] && src_addr[i*5 +: 5] == a) begin
            found = 1;
            if (src_rdy[i]) begin
              e.en[p] = 1'b1;
              e.data[p*32 +: 32] = src_data[i*32 +: 32];
            end else st[p] = 1'b1;
          end
        if (m_busy[a] && m_cnt[a] != 0) st[p] = 1'b1;
      end
    end
    if (!rsn) begin e.en = '0; e.data = '0; st = '0; end
    e.stall = |st;
    e.scnt  = m_scnt;
    e.tag   = 4'(m_tagc);
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk("bypass_en", 64'(byp_en), 64'(g.en));
    chk("bypass_data", byp_data, g.data);
    chk("stall", 64'(stall), 64'(g.stall));
    chk("stall_cnt", 64'(stall_cnt), 64'(g.scnt));
    chk("iss_tag", 64'(iss_tag), 64'(g.tag));
    @(posedge clk);
    acc = rsn && iss_valid && iss_wr_en && !e.stall &&
          iss_rd != 0 && !flush;
    if (!rsn) begin
      for (int r = 0; r < 32; r++) begin
        m_busy[r] = 0; m_cnt[r] = 0; m_tag[r] = 0;
      end
      m_tagc = 0; m_scnt = 0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (flush) m_busy[r] = 0;
        else if (acc && iss_rd == 5'(r)) begin
          m_busy[r] = 1; m_cnt[r] = iss_lat; m_tag[r] = m_tagc;
        end else begin
          nb = m_busy[r];
          if (ret_en && ret_addr == 5'(r) && ret_tag == 4'(m_tag[r]))
            nb = 0;
          if (m_busy[r] && m_cnt[r] != 0) m_cnt[r]--;
          m_busy[r] = nb;
        end
      end
      if (acc) m_tagc = (m_tagc + 1) % 16;
      if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
    #1;
  endtask

  initial begin
    idle();
    rsn = 0;
    @(posedge clk); #1;
    // reset masks live forwarding and stall sources
    set_src(0, 5'd5, 32'hCAFE_0001, 1'b1);
    set_src(1, 5'd6, 32'h0, 1'b0);
    rd(0, 5'd5); rd(1, 5'd6);
    repeat (2) cyc();
    rsn = 1; idle();
    cyc();
    // youngest source wins; disabled port and x0 stay quiet
    set_src(0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    set_src(6, 5'd5, 32'h1, 1'b1);
    set_src(3, 5'd0, 32'h1234, 1'b1);
    rd(0, 5'd5);
    cyc();
    rd_en[0] = 0; rd(1, 5'd0);
    cyc();
    rd(1, 5'd5);
    cyc();
    // latency-4 interlock then forward
    idle(); issue(5'd7, 3'd4);
    cyc();
    idle(); rd(1, 5'd7); set_src(3, 5'd7, 32'h77, 1'b1);
    repeat (4) cyc();
    chk("lat4_stall_cnt", 64'(stall_cnt), 64'd4);
    cyc();
    // cache miss stall releases same cycle as ready
    idle(); set_src(2, 5'd3, 32'h3333, 1'b0); rd(0, 5'd3);
    cyc();
    src_rdy[2] = 1'b1;
    cyc();
    // WAW: only the latest writer's tag frees the register
    idle(); issue(5'd9, 3'd7); cyc();
    issue(5'd9, 3'd7); cyc();
    idle(); rd(0, 5'd9);
    ret_en = 1; ret_addr = 5'd9; ret_tag = 4'd1; cyc();
    ret_tag = 4'd2; cyc();
    ret_en = 0; cyc();
    // flush drops a pending long-latency result
    idle(); issue(5'd4, 3'd6); cyc();
    idle(); rd(0, 5'd4); set_src(1, 5'd0, 32'h99, 1'b1); rd(1, 5'd0);
    repeat (2) cyc();
    flush = 1; cyc();
    flush = 0; repeat (2) cyc();
    // reset mid-countdown discards the entry
    idle(); issue(5'd10, 3'd5); cyc();
    idle(); rd(0, 5'd10); cyc();
    rsn = 0; set_src(0, 5'd10, 32'hAAAA, 1'b1); rd(1, 5'd10);
    repeat (2) cyc();
    rsn = 1; idle(); rd(0, 5'd10); cyc();
    // tag counter wraps past 15
    for (int k = 0; k < 18; k++) begin
      idle(); issue(5'(k % 31 + 1), 3'd0); cyc();
    end
    // random traffic on a narrow register window
    for (int k = 0; k < 300; k++) begin
      idle();
      rsn = ($urandom_range(0, 40) != 0);
      flush = ($urandom_range(0, 15) == 0);
      iss_valid = 1'($urandom); iss_wr_en = 1'($urandom);
      iss_rd = 5'($urandom_range(0, 7));
      iss_lat = 3'($urandom);
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1) rd(p, 5'($urandom_range(0, 7)));
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 2) == 0)
          set_src(i, 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) != 0));
      ret_en = 1'($urandom); ret_addr = 5'($urandom_range(0, 7));
      ret_tag = 4'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
